ivalu_issue_queue: RTL and testbench
====================================

# ivalu_issue_queue

Age-ordered reservation station feeding the packed-SIMD integer ALU (ivalu). Holds renamed vector-integer micro-ops until both source physical registers are ready, then selects the oldest ready entry each cycle and presents its op, ROB tag, destination and source tags to register read ahead of the ALU. Source readiness is tracked by tag match against the writeback wakeup buses.

## Interface
Parameters:
- DEPTH, 8 — number of entries (2..16)
- WAKE_PORTS, 2 — number of wakeup broadcast ports

Ports:
- core_clock_i  in  1  clock
- core_reset_i  in  1  asynchronous active-high reset
- flush_i  in  1  discard all entries (pipeline flush)
- enq_valid_i  in  1  enqueue request
- enq_ready_o  out  1  queue can accept (not full)
- enq_op_i  in  7  ALU opcode
- enq_rob_i  in  5  ROB index
- enq_dest_i  in  6  destination physical tag (0 = no writeback)
- enq_rs1_i, enq_rs2_i  in  6 each  source physical tags
- enq_rs1_rdy_i, enq_rs2_rdy_i  in  1 each  source already ready at rename
- wk_valid_i  in  WAKE_PORTS  wakeup strobes
- wk_tag_i  in  6*WAKE_PORTS  wakeup tags, port k at [6k+5:6k]
- iss_valid_o  out  1  an entry is selected
- iss_ready_i  in  1  downstream accepts the selected entry
- iss_op_o  out  7; iss_rob_o  out  5; iss_dest_o  out  6; iss_rs1_o, iss_rs2_o  out  6 each
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry: valid, op, rob, dest, rs1, rs1_rdy, rs2, rs2_rdy. Slot 0 oldest; occupied slots contiguous from 0.
- Enqueue: accepted when enq_valid_i & enq_ready_o & !flush_i; written at slot count (count-1 if an issue fires that cycle).
- enq_ready_o = (count != DEPTH); no enqueue into a full queue even when issuing the same cycle.
- Ready capture at enqueue: rsN_rdy = enq_rsN_rdy_i | (enq_rsN_i == 0) | any wakeup port matching enq_rsN_i this cycle.
- Wakeup: each valid entry sets rsN_rdy when any wk_valid_i[k] with wk_tag_i[k] == rsN and tag != 0.
- Select: lowest slot with valid & rs1_rdy & rs2_rdy; iss_* show its fields combinationally. iss_valid_o = 0 and iss_* = 0 when none.
- Issue fires on iss_valid_o & iss_ready_i: selected slot removed, all younger slots shift down one (collapse), ready bits updated by same-cycle wakeups during the shift.
- Flush: clears every valid bit at the edge; overrides enqueue and issue that cycle; count 0 next cycle.
- No state machine beyond per-entry valid/ready; count = valid entries.

## Timing
- Reset (async): all valid = 0, count_o = 0, enq_ready_o = 1, iss_valid_o = 0, iss_* = 0.
- Enqueue in cycle N → earliest issue in cycle N+1 (no enqueue-to-issue bypass).
- Wakeup in cycle N → matching entry selectable in N+1.
- iss_ready_i low: selection recomputed each cycle; an older entry waking up may displace the displayed one (no hold requirement).
- Downstream registers iss_*; ALU result arrives 2 cycles after issue.

## Configuration
- IVALU_IQ_SELF_WAKEUP_EN defined: on a firing issue with iss_dest_o != 0, that tag is treated as an extra wakeup port internally (applied to remaining entries and same-cycle enqueue), giving back-to-back issue of dependent ALU ops (dependent issues N+1).
- Undefined: dependents wait for the external wk_* broadcast of the result; no internal wakeup path.

## Structure
- Package biriq_ivalu_pkg: TAG_W=6, ROB_W=5, OP_W=7 localparams and typedef struct packed ivalu_iq_entry_t.
- Sub-module ivalu_iq_select: DEPTH-wide ready vector → one-hot oldest grant + found bit.

## Test plan
- Reset then enqueue op=7'h10, rob=3, dest=5, rs1=0, rs2=0 → iss_valid_o next cycle with same fields; count_o 1→0 after issue with iss_ready_i=1.
- Enqueue A (rs1=9 not ready) then B (sources ready) → B issues first; wk tag 9 in cycle N → A issues N+1.
- Fill DEPTH entries all blocked → enq_ready_o=0; one wakeup + issue → enq_ready_o=1 only the cycle after removal.
- Enqueue with rs2=12 while wk_tag_i port1=12 same cycle → entry issues next cycle without further wakeup.
- flush_i during simultaneous enqueue and issue with 5 entries → count_o=0, iss_valid_o=0 next cycle; dropped enqueue never issues.
- With IVALU_IQ_SELF_WAKEUP_EN: A dest=20 issues cycle N, B rs1=20 waiting → B issues N+1; without macro B waits for wk_tag_i=20.

Source files
------------

// File: rtl/biriq_ivalu_pkg.sv
// ============================================================================
// biriq_ivalu_pkg : shared widths and entry layout for the ivalu issue queue
// Rev 1.0
// ============================================================================
`default_nettype none

package biriq_ivalu_pkg;

  localparam int TAG_W = 6;
  localparam int ROB_W = 5;
  localparam int OP_W  = 7;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] rs1;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs2;
    logic             rs2_rdy;
  } ivalu_iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ivalu_iq_select.sv
// ============================================================================
// ivalu_iq_select : one-hot grant of the lowest (oldest) requesting slot
// Rev 1.0
// ============================================================================
`default_nettype none

module ivalu_iq_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o,
  output logic             found_o
);

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_i[i] && !found_o) begin
        grant_o[i] = 1'b1;
        found_o    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ivalu_issue_queue.sv
// ============================================================================
// ivalu_issue_queue : age-ordered collapsing reservation station for the ivalu
// Optional: IVALU_IQ_SELF_WAKEUP_EN adds the issuing dest tag as a wakeup port.
// Rev 1.0
// ============================================================================
`default_nettype none

module ivalu_issue_queue
  import biriq_ivalu_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                          core_clock_i,
  input  logic                          core_reset_i,
  input  logic                          flush_i,
  input  logic                          enq_valid_i,
  output logic                          enq_ready_o,
  input  logic [OP_W-1:0]               enq_op_i,
  input  logic [ROB_W-1:0]              enq_rob_i,
  input  logic [TAG_W-1:0]              enq_dest_i,
  input  logic [TAG_W-1:0]              enq_rs1_i,
  input  logic [TAG_W-1:0]              enq_rs2_i,
  input  logic                          enq_rs1_rdy_i,
  input  logic                          enq_rs2_rdy_i,
  input  logic [WAKE_PORTS-1:0]         wk_valid_i,
  input  logic [TAG_W*WAKE_PORTS-1:0]   wk_tag_i,
  output logic                          iss_valid_o,
  input  logic                          iss_ready_i,
  output logic [OP_W-1:0]               iss_op_o,
  output logic [ROB_W-1:0]              iss_rob_o,
  output logic [TAG_W-1:0]              iss_dest_o,
  output logic [TAG_W-1:0]              iss_rs1_o,
  output logic [TAG_W-1:0]              iss_rs2_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef IVALU_IQ_SELF_WAKEUP_EN
  localparam int NW = WAKE_PORTS + 1;
`else
  localparam int NW = WAKE_PORTS;
`endif

  ivalu_iq_entry_t      entries_q [DEPTH];
  ivalu_iq_entry_t      entries_d [DEPTH];
  ivalu_iq_entry_t      upd       [DEPTH+1];
  ivalu_iq_entry_t      iss_sel;
  ivalu_iq_entry_t      enq_entry;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [CNT_W-1:0]     wr_idx;
  logic [DEPTH-1:0]     req;
  logic [DEPTH-1:0]     grant;
  logic                 found;
  logic                 fire;
  logic                 enq_fire;
  logic                 seen;
  logic [NW-1:0]        wk_vld;
  logic [NW*TAG_W-1:0]  wk_tags;

  function automatic logic wake_hit(input logic [NW-1:0]       vld,
                                    input logic [NW*TAG_W-1:0] tags,
                                    input logic [TAG_W-1:0]    tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag) && (tag != '0)) hit = 1'b1;
    end
    return hit;
  endfunction

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_req
      assign req[i] = entries_q[i].valid & entries_q[i].rs1_rdy & entries_q[i].rs2_rdy;
    end
  endgenerate

  ivalu_iq_select #(.DEPTH(DEPTH)) u_select (
    .req_i   (req),
    .grant_o (grant),
    .found_o (found)
  );

  always_comb begin
    iss_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) iss_sel = iss_sel | entries_q[i];
    end
  end

  assign iss_valid_o = found;
  assign iss_op_o    = iss_sel.op;
  assign iss_rob_o   = iss_sel.rob;
  assign iss_dest_o  = iss_sel.dest;
  assign iss_rs1_o   = iss_sel.rs1;
  assign iss_rs2_o   = iss_sel.rs2;

  assign enq_ready_o = (count_q != CNT_W'(DEPTH));
  assign count_o     = count_q;
  assign fire        = found & iss_ready_i & ~flush_i;
  assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;

`ifdef IVALU_IQ_SELF_WAKEUP_EN
  // The issuing result tag acts as one extra broadcast, so dependents issue next cycle.
  assign wk_vld  = {fire & (iss_sel.dest != '0), wk_valid_i};
  assign wk_tags = {iss_sel.dest, wk_tag_i};
`else
  assign wk_vld  = wk_valid_i;
  assign wk_tags = wk_tag_i;
`endif

  always_comb begin
    enq_entry         = '0;
    enq_entry.valid   = 1'b1;
    enq_entry.op      = enq_op_i;
    enq_entry.rob     = enq_rob_i;
    enq_entry.dest    = enq_dest_i;
    enq_entry.rs1     = enq_rs1_i;
    enq_entry.rs2     = enq_rs2_i;
    enq_entry.rs1_rdy = enq_rs1_rdy_i | (enq_rs1_i == '0) | wake_hit(wk_vld, wk_tags, enq_rs1_i);
    enq_entry.rs2_rdy = enq_rs2_rdy_i | (enq_rs2_i == '0) | wake_hit(wk_vld, wk_tags, enq_rs2_i);
  end

  // Wakeups applied in place first, so entries that shift still pick them up.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd[i] = entries_q[i];
      if (entries_q[i].valid) begin
        upd[i].rs1_rdy = entries_q[i].rs1_rdy | wake_hit(wk_vld, wk_tags, entries_q[i].rs1);
        upd[i].rs2_rdy = entries_q[i].rs2_rdy | wake_hit(wk_vld, wk_tags, entries_q[i].rs2);
      end
    end
    upd[DEPTH] = '0;
  end

  always_comb begin
    seen   = 1'b0;
    wr_idx = count_q - CNT_W'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      seen         = seen | grant[i];
      entries_d[i] = (fire && seen) ? upd[i+1] : upd[i];
      if (enq_fire && (wr_idx == CNT_W'(i))) entries_d[i] = enq_entry;
      if (flush_i) entries_d[i] = '0;
    end
    if (flush_i) count_d = '0;
    else         count_d = count_q + CNT_W'(enq_fire) - CNT_W'(fire);
  end

  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ivalu_issue_queue.sv
// ============================================================================
// tb_ivalu_issue_queue : scoreboard bench for ivalu_issue_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ivalu_issue_queue;

  localparam int DEPTH = 8;
  localparam int WP    = 2;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          enq_valid_i;
  logic          enq_ready_o;
  logic [6:0]    enq_op_i;
  logic [4:0]    enq_rob_i;
  logic [5:0]    enq_dest_i;
  logic [5:0]    enq_rs1_i;
  logic [5:0]    enq_rs2_i;
  logic          enq_rs1_rdy_i;
  logic          enq_rs2_rdy_i;
  logic [WP-1:0] wk_valid_i;
  logic [6*WP-1:0] wk_tag_i;
  logic          iss_valid_o;
  logic          iss_ready_i;
  logic [6:0]    iss_op_o;
  logic [4:0]    iss_rob_o;
  logic [5:0]    iss_dest_o;
  logic [5:0]    iss_rs1_o;
  logic [5:0]    iss_rs2_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [29:0] sb [$];

  ivalu_issue_queue #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
    .core_clock_i  (clk),
    .core_reset_i  (rst),
    .flush_i       (flush_i),
    .enq_valid_i   (enq_valid_i),
    .enq_ready_o   (enq_ready_o),
    .enq_op_i      (enq_op_i),
    .enq_rob_i     (enq_rob_i),
    .enq_dest_i    (enq_dest_i),
    .enq_rs1_i     (enq_rs1_i),
    .enq_rs2_i     (enq_rs2_i),
    .enq_rs1_rdy_i (enq_rs1_rdy_i),
    .enq_rs2_rdy_i (enq_rs2_rdy_i),
    .wk_valid_i    (wk_valid_i),
    .wk_tag_i      (wk_tag_i),
    .iss_valid_o   (iss_valid_o),
    .iss_ready_i   (iss_ready_i),
    .iss_op_o      (iss_op_o),
    .iss_rob_o     (iss_rob_o),
    .iss_dest_o    (iss_dest_o),
    .iss_rs1_o     (iss_rs1_o),
    .iss_rs2_o     (iss_rs2_o),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] rec(input logic [6:0] op, input logic [4:0] rob,
                                      input logic [5:0] dest, input logic [5:0] rs1,
                                      input logic [5:0] rs2);
    return {op, rob, dest, rs1, rs2};
  endfunction

  task automatic idle_in();
    enq_valid_i = 1'b0; flush_i = 1'b0; wk_valid_i = '0; wk_tag_i = '0;
    enq_op_i = '0; enq_rob_i = '0; enq_dest_i = '0; enq_rs1_i = '0; enq_rs2_i = '0;
    enq_rs1_rdy_i = 1'b0; enq_rs2_rdy_i = 1'b0;
  endtask

  task automatic drive_enq(input logic [6:0] op, input logic [4:0] rob, input logic [5:0] dest,
                           input logic [5:0] rs1, input logic r1, input logic [5:0] rs2,
                           input logic r2);
    enq_valid_i = 1'b1; enq_op_i = op; enq_rob_i = rob; enq_dest_i = dest;
    enq_rs1_i = rs1; enq_rs1_rdy_i = r1; enq_rs2_i = rs2; enq_rs2_rdy_i = r2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Every accepted issue must match the head of the expected-order queue.
  always @(negedge clk) begin
    if (!rst && iss_valid_o && iss_ready_i && !flush_i) begin
      if (sb.size() == 0) check("unexpected_issue", {34'd0, iss_op_o, iss_rob_o, iss_dest_o, iss_rs1_o, iss_rs2_o}, 64'd0);
      else check("issue_fields", {34'd0, iss_op_o, iss_rob_o, iss_dest_o, iss_rs1_o, iss_rs2_o}, {34'd0, sb.pop_front()});
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; iss_ready_i = 1'b1;
    idle_in();
    #3;
    check("rst_count", count_o, 0);
    check("rst_enq_ready", enq_ready_o, 1);
    check("rst_iss_valid", iss_valid_o, 0);
    check("rst_iss_op", iss_op_o, 0);
    @(negedge clk); rst = 1'b0;
    next_cycle();

    // Basic enqueue -> issue
    drive_enq(7'h10, 5'd3, 6'd5, 6'd0, 1'b0, 6'd0, 1'b0);
    sb.push_back(rec(7'h10, 5'd3, 6'd5, 6'd0, 6'd0));
    mid(); check("t1_no_bypass", iss_valid_o, 0); next_cycle(); idle_in();
    mid(); check("t1_count1", count_o, 1); check("t1_iss_valid", iss_valid_o, 1); next_cycle();
    mid(); check("t1_count0", count_o, 0); check("t1_iss_op_zero", iss_op_o, 0); next_cycle();

    // Younger ready entry bypasses older blocked one
    sb.push_back(rec(7'h21, 5'd2, 6'd7, 6'd1, 6'd2));
    sb.push_back(rec(7'h20, 5'd1, 6'd6, 6'd9, 6'd0));
    drive_enq(7'h20, 5'd1, 6'd6, 6'd9, 1'b0, 6'd0, 1'b0);
    mid(); next_cycle();
    drive_enq(7'h21, 5'd2, 6'd7, 6'd1, 1'b1, 6'd2, 1'b1);
    mid(); check("t2_a_blocked", iss_valid_o, 0); next_cycle(); idle_in();
    mid(); check("t2_b_first", iss_rob_o, 2); next_cycle();
    wk_valid_i = 2'b01; wk_tag_i = {6'd0, 6'd9};
    mid(); check("t2_wake_latency", iss_valid_o, 0); next_cycle(); idle_in();
    mid(); check("t2_a_after_wake", iss_rob_o, 1); next_cycle();
    mid(); check("t2_empty", count_o, 0); next_cycle();

    // Fill with blocked entries, reject overflow, collapse ordering
    for (int i = 0; i < DEPTH; i++) begin
      drive_enq(7'(7'h30 + i), 5'(i), 6'(i + 1), 6'(32 + i), 1'b0, 6'd0, 1'b0);
      mid(); next_cycle();
    end
    drive_enq(7'h3f, 5'd31, 6'd9, 6'd0, 1'b1, 6'd0, 1'b1);
    mid(); check("t3_full_count", count_o, DEPTH); check("t3_full_ready", enq_ready_o, 0);
    check("t3_all_blocked", iss_valid_o, 0); next_cycle(); idle_in();
    wk_valid_i = 2'b01; wk_tag_i = {6'd0, 6'd35};
    mid(); check("t3_overflow_rejected", count_o, DEPTH); next_cycle(); idle_in();
    sb.push_back(rec(7'h33, 5'd3, 6'd4, 6'd35, 6'd0));
    mid(); check("t3_wake_issue", iss_rob_o, 3); check("t3_ready_still_low", enq_ready_o, 0); next_cycle();
    sb.push_back(rec(7'h30, 5'd0, 6'd1, 6'd32, 6'd0));
    sb.push_back(rec(7'h37, 5'd7, 6'd8, 6'd39, 6'd0));
    wk_valid_i = 2'b11; wk_tag_i = {6'd39, 6'd32};
    mid(); check("t3_ready_after", enq_ready_o, 1); check("t3_count7", count_o, 7); next_cycle(); idle_in();
    mid(); check("t3_oldest_first", iss_rob_o, 0); next_cycle();
    mid(); check("t3_collapse_wake", iss_rob_o, 7); check("t3_count6", count_o, 6); next_cycle();

    // Flush with simultaneous enqueue and issue (5 entries held)
    wk_valid_i = 2'b01; wk_tag_i = {6'd0, 6'd33};
    mid(); check("t5_count5", count_o, 5); next_cycle(); idle_in();
    flush_i = 1'b1;
    drive_enq(7'h3e, 5'd20, 6'd10, 6'd0, 1'b1, 6'd0, 1'b1);
    mid(); check("t5_sel_before_flush", iss_rob_o, 1); next_cycle(); idle_in();
    mid(); check("t5_count0", count_o, 0); check("t5_iss_valid0", iss_valid_o, 0); next_cycle();
    mid(); check("t5_dropped_enq", iss_valid_o, 0); next_cycle();

    // Wakeup on port 1 in the enqueue cycle
    wk_valid_i = 2'b10; wk_tag_i = {6'd12, 6'd0};
    drive_enq(7'h44, 5'd9, 6'd11, 6'd0, 1'b0, 6'd12, 1'b0);
    sb.push_back(rec(7'h44, 5'd9, 6'd11, 6'd0, 6'd12));
    mid(); next_cycle(); idle_in();
    mid(); check("t4_enq_wake_valid", iss_valid_o, 1); check("t4_enq_wake_rs2", iss_rs2_o, 12); next_cycle();
    mid(); check("t4_count0", count_o, 0); next_cycle();

    // Dependent issue: self-wakeup vs external broadcast
    sb.push_back(rec(7'h50, 5'd10, 6'd20, 6'd0, 6'd0));
    sb.push_back(rec(7'h51, 5'd11, 6'd21, 6'd20, 6'd0));
    drive_enq(7'h51, 5'd11, 6'd21, 6'd20, 1'b0, 6'd0, 1'b0);
    mid(); next_cycle();
    drive_enq(7'h50, 5'd10, 6'd20, 6'd0, 1'b1, 6'd0, 1'b1);
    mid(); check("t6_b_blocked", iss_valid_o, 0); next_cycle(); idle_in();
    mid(); check("t6_a_issue", iss_rob_o, 10); next_cycle();
`ifdef IVALU_IQ_SELF_WAKEUP_EN
    mid(); check("t6_b_back_to_back", iss_rob_o, 11); next_cycle();
`else
    wk_valid_i = 2'b01; wk_tag_i = {6'd0, 6'd20};
    mid(); check("t6_b_waits", iss_valid_o, 0); next_cycle(); idle_in();
    mid(); check("t6_b_after_wk", iss_rob_o, 11); next_cycle();
`endif

    mid();
    check("final_sb_empty", sb.size(), 0);
    check("final_count", count_o, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
